// File: rtl/cpu_trap_ctrl.sv
// Machine-mode trap controller: prioritises interrupts, exceptions and privilege violations,
// holds trap CSR state and sequences trap entry / mret through flush and redirect.
// Optional: define CPU_TRAP_IRQ_SYNC_EN to add a 2-flop synchroniser on irq.
module cpu_trap_ctrl #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_EXC       = 4,
  parameter int unsigned NUM_IRQ       = 4,
  parameter int unsigned CAUSE_W       = 5,
  parameter int unsigned ILLEGAL_CAUSE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [XLEN-1:0]    instr_pc,
  input  logic [1:0]         required_priv,
  input  logic               csr_write,
  input  logic [11:0]        csr_addr,
  input  logic [NUM_EXC-1:0] exc_req,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mret,
  input  logic [XLEN-1:0]    mtvec,
  input  logic               ie_we,
  input  logic               ie_wdata,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic [XLEN-1:0]    trap_epc,
  output logic [XLEN-1:0]    trap_tval,
  output logic [1:0]         priv,
  output logic               mie,
  output logic               busy
);

  localparam int unsigned IDX_W = CAUSE_W - 1;
  localparam logic [1:0]  PRIV_M = 2'b11;
  localparam logic [1:0]  PRIV_U = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     target_q, target_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [XLEN-1:0]     epc_q, epc_d;
  logic [XLEN-1:0]     tval_q, tval_d;
  logic [1:0]          priv_q, priv_d;
  logic                mie_q, mie_d;
  logic                mpie_q, mpie_d;
  logic [1:0]          mpp_q, mpp_d;
  logic                is_mret_q, is_mret_d;

  logic [NUM_IRQ-1:0]  irq_s;
  logic [NUM_IRQ-1:0]  irq_pend;
  logic                irq_any, exc_any, illegal;
  logic                trap_evt, mret_evt;
  logic [IDX_W-1:0]    irq_idx, exc_idx;
  logic [XLEN-1:0]     vec_base, trap_target;
  logic                unused_csr_bits;

`ifdef CPU_TRAP_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;

  // Two-stage synchroniser for asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= irq;
      irq_s2_q <= irq_s1_q;
    end
  end
  assign irq_s = irq_s2_q;
`else
  assign irq_s = irq;
`endif

  assign unused_csr_bits = ^{csr_addr[11:10], csr_addr[7:0]};

  assign irq_pend = irq_s & irq_en & {NUM_IRQ{mie_q}};
  assign irq_any  = |irq_pend;
  assign exc_any  = |exc_req;
  assign illegal  = (priv_q < required_priv) || (csr_write && (priv_q < csr_addr[9:8]));

  // Lowest-index priority encoders
  always_comb begin
    irq_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = IDX_W'(i);
    end
  end

  always_comb begin
    exc_idx = '0;
    for (int i = int'(NUM_EXC) - 1; i >= 0; i--) begin
      if (exc_req[i]) exc_idx = IDX_W'(i);
    end
  end

  assign trap_evt = (state_q == ST_IDLE) && instr_valid && (irq_any || exc_any || illegal);
  assign mret_evt = (state_q == ST_IDLE) && instr_valid && mret && !trap_evt;

  // Only interrupts are offset in vectored mode; exceptions land on the base
  assign vec_base    = {mtvec[XLEN-1:2], 2'b00};
  assign trap_target = ((mtvec[1:0] == 2'b01) && irq_any)
                       ? vec_base + (XLEN'(irq_idx) << 2)
                       : vec_base;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    priv_d    = priv_q;
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    mpp_d     = mpp_q;
    is_mret_d = is_mret_q;

    unique case (state_q)
      ST_IDLE: begin
        if (trap_evt) begin
          state_d   = ST_FLUSH;
          epc_d     = instr_pc;
          mpie_d    = mie_q;
          mie_d     = 1'b0;
          mpp_d     = priv_q;
          target_d  = trap_target;
          is_mret_d = 1'b0;
          if (irq_any) begin
            cause_d = {1'b1, irq_idx};
            tval_d  = '0;
          end else if (exc_any) begin
            cause_d = {1'b0, exc_idx};
            tval_d  = exc_tval;
          end else begin
            cause_d = {1'b0, IDX_W'(ILLEGAL_CAUSE)};
            tval_d  = '0;
          end
        end else if (mret_evt) begin
          state_d   = ST_FLUSH;
          target_d  = epc_q;
          is_mret_d = 1'b1;
        end else if (ie_we) begin
          mie_d = ie_wdata;
        end
      end
      ST_FLUSH: begin
        if (flush_ack) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
        // Privilege stack moves as the redirect retires
        if (is_mret_q) begin
          priv_d = mpp_q;
          mie_d  = mpie_q;
          mpie_d = 1'b1;
          mpp_d  = PRIV_U;
        end else begin
          priv_d = PRIV_M;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      priv_q    <= PRIV_M;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mpp_q     <= PRIV_U;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      priv_q    <= priv_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mpp_q     <= mpp_d;
      is_mret_q <= is_mret_d;
    end
  end

  // Handshake strobes decode directly from state so reset removes them at once
  assign flush_req      = (state_q == ST_FLUSH);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = target_q;
  assign busy           = (state_q != ST_IDLE);
  assign trap_cause     = cause_q;
  assign trap_epc       = epc_q;
  assign trap_tval      = tval_q;
  assign priv           = priv_q;
  assign mie            = mie_q;

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Directed scoreboard bench for cpu_trap_ctrl: expected redirects are queued when an
// event is driven and compared when the DUT strobes redirect_valid.
module tb_cpu_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [1:0]  required_priv;
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [3:0]  exc_req;
  logic [31:0] exc_tval;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic        mret;
  logic [31:0] mtvec;
  logic        ie_we;
  logic        ie_wdata;
  logic        flush_req;
  logic        flush_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic [1:0]  priv;
  logic        mie;
  logic        busy;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic        mie;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  cpu_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .required_priv(required_priv), .csr_write(csr_write), .csr_addr(csr_addr),
    .exc_req(exc_req), .exc_tval(exc_tval), .irq(irq), .irq_en(irq_en), .mret(mret),
    .mtvec(mtvec), .ie_we(ie_we), .ie_wdata(ie_wdata), .flush_req(flush_req),
    .flush_ack(flush_ack), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval), .priv(priv),
    .mie(mie), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 0; instr_pc = '0; required_priv = 2'b00; csr_write = 0; csr_addr = '0;
    exc_req = '0; exc_tval = '0; mret = 0; ie_we = 0; ie_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  // Wait for the redirect strobe, compare against the oldest expectation, then check retirement
  task automatic wait_redirect(input string tag, output int n);
    exp_t e;
    n = 0;
    while (!redirect_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_seen"}, 64'(redirect_valid), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_pc"}, 64'(redirect_pc), 64'(e.pc));
      check({tag, "_cause"}, 64'(trap_cause), 64'(e.cause));
      check({tag, "_epc"}, 64'(trap_epc), 64'(e.epc));
      check({tag, "_tval"}, 64'(trap_tval), 64'(e.tval));
      step();
      check({tag, "_strobe_once"}, 64'(redirect_valid), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_priv"}, 64'(priv), 64'(e.priv));
      check({tag, "_mie"}, 64'(mie), 64'(e.mie));
    end
  endtask

  initial begin
    clear_inputs();
    irq = '0; irq_en = '0; mtvec = 32'h100; flush_ack = 1;
    do_reset();

    // Reset state
    check("rst_flush_req", 64'(flush_req), 64'd0);
    check("rst_redirect", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_priv", 64'(priv), 64'd3);
    check("rst_mie", 64'(mie), 64'd0);
    check("rst_cause", 64'(trap_cause), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // 1: exception, lowest set index wins, direct mode
    instr_valid = 1; instr_pc = 32'h40; exc_req = 4'b0110; exc_tval = 32'hDEAD;
    sb.push_back('{pc: 32'h100, cause: 5'd1, epc: 32'h40, tval: 32'hDEAD, priv: 2'd3, mie: 1'b0});
    step();
    clear_inputs();
    check("t1_flush_req", 64'(flush_req), 64'd1);
    check("t1_no_early_redirect", 64'(redirect_valid), 64'd0);
    wait_redirect("t1", lat);
    check("t1_latency", 64'(lat), 64'd1);

    // 2: mret from reset drops to U, then a CSR privilege violation traps back to M
    do_reset();
    instr_valid = 1; mret = 1; instr_pc = 32'h60;
    sb.push_back('{pc: 32'h0, cause: 5'd0, epc: 32'h0, tval: 32'h0, priv: 2'd0, mie: 1'b0});
    step();
    clear_inputs();
    wait_redirect("t2_mret", lat);
    instr_valid = 1; instr_pc = 32'h80; csr_write = 1; csr_addr = 12'h300; required_priv = 2'd0;
    exc_tval = 32'hBEEF;
    sb.push_back('{pc: 32'h100, cause: 5'd2, epc: 32'h80, tval: 32'h0, priv: 2'd3, mie: 1'b0});
    step();
    clear_inputs();
    wait_redirect("t2_illegal", lat);

    // 3: interrupt beats exception, vectored target
    ie_we = 1; ie_wdata = 1;
    step();
    clear_inputs();
    check("t3_mie_set", 64'(mie), 64'd1);
    irq_en = 4'b1111; irq = 4'b1100; mtvec = 32'h201;
    step(); step(); step();
    instr_valid = 1; instr_pc = 32'h90; exc_req = 4'b0001; exc_tval = 32'h1234;
    sb.push_back('{pc: 32'h208, cause: 5'h12, epc: 32'h90, tval: 32'h0, priv: 2'd3, mie: 1'b0});
    step();
    clear_inputs();
    irq = '0;
    wait_redirect("t3", lat);

    // 4: held flush_ack low; events during FLUSH are ignored
    mtvec = 32'h100; flush_ack = 0;
    instr_valid = 1; instr_pc = 32'hA0; exc_req = 4'b0100; exc_tval = 32'h55;
    sb.push_back('{pc: 32'h100, cause: 5'd2, epc: 32'hA0, tval: 32'h55, priv: 2'd3, mie: 1'b0});
    step();
    for (int k = 0; k < 5; k++) begin
      exc_req = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      exc_tval = 32'hBAD;
      instr_pc = 32'hF00;
      check($sformatf("t4_flush_held_%0d", k), 64'(flush_req), 64'd1);
      check($sformatf("t4_no_redirect_%0d", k), 64'(redirect_valid), 64'd0);
      if (k == 4) flush_ack = 1;
      step();
    end
    clear_inputs();
    wait_redirect("t4", lat);

    // 5a: trap and mret together, trap wins
    instr_valid = 1; mret = 1; instr_pc = 32'hB0; exc_req = 4'b1000; exc_tval = 32'h77;
    sb.push_back('{pc: 32'h100, cause: 5'd3, epc: 32'hB0, tval: 32'h77, priv: 2'd3, mie: 1'b0});
    step();
    clear_inputs();
    wait_redirect("t5_mret_drop", lat);

    // 5b: ie_we alongside a trap event is discarded
    ie_we = 1; ie_wdata = 1;
    step();
    check("t5_mie_pre", 64'(mie), 64'd1);
    instr_valid = 1; instr_pc = 32'hC0; exc_req = 4'b0001; exc_tval = 32'h99;
    ie_we = 1; ie_wdata = 1;
    sb.push_back('{pc: 32'h100, cause: 5'd0, epc: 32'hC0, tval: 32'h99, priv: 2'd3, mie: 1'b0});
    step();
    clear_inputs();
    wait_redirect("t5_ie_we", lat);

    // 6: asynchronous reset during FLUSH
    flush_ack = 0;
    instr_valid = 1; instr_pc = 32'hD0; exc_req = 4'b0010;
    step();
    clear_inputs();
    check("t6_in_flush", 64'(flush_req), 64'd1);
    #2;
    rst_n = 0;
    #1;
    check("t6_flush_drop", 64'(flush_req), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_priv", 64'(priv), 64'd3);
    check("t6_redirect", 64'(redirect_valid), 64'd0);
    step();
    rst_n = 1;
    flush_ack = 1;
    step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
